// File: rtl/data_mem_arbiter_if.sv
// Bundle of the core load/store port, the host burst port and the data memory
// port shared by data_mem_arbiter and whatever sits around it.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
);
  // Handshake: a requester holds *_req (and its fields) while it wants the memory;
  // *_gnt high in the same cycle means that access happened this cycle. A request
  // without a grant is simply retried on a later cycle; nothing is queued.
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [LEN_W-1:0]  host_len;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_last;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rdata,
    output host_req, host_we, host_addr, host_len, host_wdata,
    input  host_gnt, host_last, host_rdata,
    input  mem_we, mem_read_addr, mem_write_addr, mem_write_data,
    output mem_read_data
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rdata,
    input  host_req, host_we, host_addr, host_len, host_wdata,
    output host_gnt, host_last, host_rdata,
    output mem_we, mem_read_addr, mem_write_addr, mem_write_data,
    input  mem_read_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the core (single accesses) and a
// host port (non-preemptible bursts), round-robin when both ask in IDLE.
module data_mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_arbiter_if.slave   bus,
  output logic                dbg_state
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]  burst_len_q, burst_len_d;
  logic [ADDR_W-1:0] base_addr_q, base_addr_d;

  logic              core_win;
  logic              host_win;
  logic              in_burst;
  logic [ADDR_W-1:0] burst_addr;
  logic [ADDR_W-1:0] mem_addr;

  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      burst_len_q  <= '0;
      base_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_len_q  <= burst_len_d;
      base_addr_q  <= base_addr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    burst_len_d  = burst_len_q;
    base_addr_d  = base_addr_q;
    if (core_win) begin
      last_grant_d = 1'b0;
    end else if (host_win) begin
      last_grant_d = 1'b1;
      base_addr_d  = bus.host_addr;
      burst_len_d  = bus.host_len;
      if (bus.host_len != '0) begin
        beat_cnt_d = LEN_W'(1);
        state_d    = ST_BURST;
      end
    end else if (in_burst) begin
      if (beat_cnt_q == burst_len_q) begin
        beat_cnt_d = '0;
        state_d    = ST_IDLE;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
    end
  end

  // Output logic: arbitration decision and memory port steering
  always_comb begin
    core_win = 1'b0;
    host_win = 1'b0;
    in_burst = 1'b0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        // The requester that did not win last time takes a contended cycle.
        core_win = bus.core_req & (~bus.host_req | last_grant_q);
        host_win = bus.host_req & (~bus.core_req | ~last_grant_q);
      end else begin
        in_burst = 1'b1;
      end
    end

    burst_addr = base_addr_q + ADDR_W'(beat_cnt_q);

    bus.core_gnt   = core_win;
    bus.core_stall = bus.core_req & ~core_win;
    bus.core_rdata = bus.mem_read_data;
    bus.host_gnt   = host_win | in_burst;
    bus.host_last  = (host_win & (bus.host_len == '0)) |
                     (in_burst & (beat_cnt_q == burst_len_q));
    bus.host_rdata = bus.mem_read_data;

    bus.mem_we         = 1'b0;
    mem_addr           = '0;
    bus.mem_write_data = '0;
    if (core_win) begin
      bus.mem_we         = bus.core_we;
      mem_addr           = bus.core_addr;
      bus.mem_write_data = bus.core_wdata;
    end else if (host_win) begin
      bus.mem_we         = bus.host_we;
      mem_addr           = bus.host_addr;
      bus.mem_write_data = bus.host_wdata;
    end else if (in_burst) begin
      bus.mem_we         = bus.host_we;
      mem_addr           = burst_addr;
      bus.mem_write_data = bus.host_wdata;
    end
    bus.mem_read_addr  = mem_addr;
    bus.mem_write_addr = mem_addr;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: per-cycle expectations go through a
// scoreboard queue, with a bench-owned memory and reference copy.
module tb_data_mem_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;
  localparam int EXP_W  = 5 + ADDR_W + DATA_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Data memory: combinational read, write on rising clk
  logic [DATA_W-1:0] tb_mem [32];
  assign bus.mem_read_data = tb_mem[bus.mem_read_addr];
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_write_addr] <= bus.mem_write_data;
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0]  exp_q[$];
  logic [DATA_W-1:0] ref_mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, queue the expected outputs, compare mid-cycle.
  task automatic cyc(input logic r,
                     input logic creq, input logic cwe, input logic [ADDR_W-1:0] caddr,
                     input logic [DATA_W-1:0] cwd,
                     input logic hreq, input logic hwe, input logic [ADDR_W-1:0] haddr,
                     input logic [LEN_W-1:0] hlen, input logic [DATA_W-1:0] hwd,
                     input logic ecg, input logic ehg, input logic ehl, input logic ewe,
                     input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ewd);
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] o;
    rst            = r;
    bus.core_req   = creq;
    bus.core_we    = cwe;
    bus.core_addr  = caddr;
    bus.core_wdata = cwd;
    bus.host_req   = hreq;
    bus.host_we    = hwe;
    bus.host_addr  = haddr;
    bus.host_len   = hlen;
    bus.host_wdata = hwd;
    exp_q.push_back({ecg, creq & ~ecg, ehg, ehl, ewe, ea, ewd, ref_mem[ea]});
    if (ewe) ref_mem[ea] = ewd;
    @(negedge clk);
    e = exp_q.pop_front();
    o = {bus.core_gnt, bus.core_stall, bus.host_gnt, bus.host_last, bus.mem_we,
         bus.mem_write_addr, bus.mem_write_data, bus.core_rdata};
    check("ctrl_outputs", 32'(o[EXP_W-1:DATA_W]), 32'(e[EXP_W-1:DATA_W]));
    check("mem_read_addr", 32'(bus.mem_read_addr), 32'(ea));
    if (ecg) check("core_rdata", 32'(bus.core_rdata), 32'(e[DATA_W-1:0]));
    if (ehg) check("host_rdata", 32'(bus.host_rdata), 32'(e[DATA_W-1:0]));
    @(posedge clk);
    #1;
  endtask

  task automatic core_only(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cyc(1'b0, 1'b1, we, a, d, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, we, a, d);
  endtask

  task automatic reset_cycle(input logic creq, input logic hreq);
    cyc(1'b1, creq, 1'b1, 5'd7, 8'hEE, hreq, 1'b1, 5'd9, 3'd2, 8'hDD,
        1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    rst = 1'b1;
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_len = '0;
    bus.host_wdata = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;

    // Reset: everything quiet, stall mirrors core_req
    reset_cycle(1'b1, 1'b1);
    reset_cycle(1'b1, 1'b0);

    // Prefill memory through the core port with values below 0x80
    for (int i = 0; i < 32; i++) begin
      d = DATA_W'($urandom_range(0, 127));
      core_only(1'b1, ADDR_W'(i), d);
    end

    // Core write then read-back
    core_only(1'b1, 5'd3, 8'h5A);
    core_only(1'b0, 5'd3, 8'h00);

    // After reset, contended: core first, then single-beat host
    reset_cycle(1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0, 5'd3, 3'd0, 8'h00,
        1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 5'd5, 8'h00, 1'b1, 1'b0, 5'd3, 3'd0, 8'h00,
        1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 8'h00);

    // Core wins once so the host takes the next contended cycle
    core_only(1'b0, 5'd0, 8'h00);

    // Wrapping 4-beat write at 30 with the core stalled; base/len ignored after beat 0
    for (int i = 0; i < 4; i++) begin
      a = ADDR_W'(30 + i);
      d = DATA_W'(8'h11 * (i + 1));
      cyc(1'b0, 1'b1, 1'b0, 5'd9, 8'h00,
          1'b1, 1'b1, (i == 0) ? 5'd30 : 5'd5, (i == 0) ? 3'd3 : 3'd7, d,
          1'b0, 1'b1, (i == 3), 1'b1, a, d);
    end
    // Core gets the 5th cycle despite host_req
    cyc(1'b0, 1'b1, 1'b0, 5'd30, 8'h00, 1'b1, 1'b0, 5'd0, 3'd7, 8'h00,
        1'b1, 1'b0, 1'b0, 1'b0, 5'd30, 8'h00);

    // 8-beat read from 0
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, (i != 7), 1'b0, (i == 0) ? 5'd0 : 5'd20,
          3'd7, 8'h00, 1'b0, 1'b1, (i == 7), 1'b0, ADDR_W'(i), 8'h00);
    end

    // Idle cycle: nothing granted
    cyc(1'b0, 1'b0, 1'b1, 5'd4, 8'h77, 1'b0, 1'b1, 5'd6, 3'd0, 8'h66,
        1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // 6-beat write at 16 interrupted by reset on beat 2
    for (int i = 0; i < 2; i++) begin
      d = DATA_W'(8'hA0 + i);
      cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd16, 3'd5, d,
          1'b0, 1'b1, 1'b0, 1'b1, ADDR_W'(16 + i), d);
    end
    cyc(1'b1, 1'b1, 1'b0, 5'd18, 8'h00, 1'b1, 1'b1, 5'd16, 3'd5, 8'hA2,
        1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 1'b0, 5'd18, 8'h00, 1'b0, 1'b1, 5'd16, 3'd5, 8'hA3,
        1'b1, 1'b0, 1'b0, 1'b0, 5'd18, 8'h00);
    for (int i = 16; i < 22; i++) core_only(1'b0, ADDR_W'(i), 8'h00);

    // Back-to-back single-beat host bursts vs a held core request: strict alternation
    for (int k = 0; k < 3; k++) begin
      d = DATA_W'(8'hC0 + k);
      cyc(1'b0, 1'b1, 1'b0, 5'd10, 8'h00, 1'b1, 1'b1, 5'd10, 3'd0, d,
          1'b0, 1'b1, 1'b1, 1'b1, 5'd10, d);
      cyc(1'b0, 1'b1, 1'b0, 5'd10, 8'h00, 1'b1, 1'b1, 5'd10, 3'd0, d,
          1'b1, 1'b0, 1'b0, 1'b0, 5'd10, 8'h00);
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Arbiter that shares the single data memory (5-bit address, 8-bit data, combinational read, write on rising `clk`) between two requesters. Requester 0 is the processor core's load/store path. Requester 1 is a host port used for program-data loading and debug readout in bursts. The block sits between both requesters and the data memory. It drives the memory's write enable, addresses and write data, and stalls the core while the host owns the memory.

## Interface
- `ADDR_W`, 5, data memory address width
- `DATA_W`, 8, data word width
- `LEN_W`, 3, host burst length field width; max burst = 2^LEN_W beats

- `clk`  in  1  rising-edge clock, the only clock
- `rst`  in  1  synchronous, active-high reset
- `core_req`  in  1  core requests one access this cycle
- `core_we`  in  1  1 = write, 0 = read
- `core_addr`  in  ADDR_W  core address
- `core_wdata`  in  DATA_W  core write data
- `core_gnt`  out  1  core access performed this cycle
- `core_stall`  out  1  `core_req & ~core_gnt`
- `core_rdata`  out  DATA_W  `mem_read_data`, valid when `core_gnt` is high
- `host_req`  in  1  host requests a burst (sampled only in IDLE)
- `host_we`  in  1  burst direction, sampled per beat
- `host_addr`  in  ADDR_W  burst base address, sampled on beat 0 only
- `host_len`  in  LEN_W  beats minus 1, sampled on beat 0 only
- `host_wdata`  in  DATA_W  write data for the current beat
- `host_gnt`  out  1  a host beat is performed this cycle
- `host_last`  out  1  current granted beat is the final one
- `host_rdata`  out  DATA_W  `mem_read_data`, valid when `host_gnt` is high
- `mem_we`  out  1  data memory write enable
- `mem_read_addr`  out  ADDR_W  data memory read address
- `mem_write_addr`  out  ADDR_W  data memory write address (always equal to `mem_read_addr`)
- `mem_write_data`  out  DATA_W  data memory write data
- `mem_read_data`  in  DATA_W  data memory read data (combinational)

## Operation
- FSM with states IDLE and BURST. Registered state:
  - `state`
  - `last_grant`: 0 = core, 1 = host
  - `beat_cnt` (LEN_W bits)
  - `burst_len` (LEN_W bits)
  - `base_addr` (ADDR_W bits)
- Arbitration in IDLE is combinational on the current requests:
  - Only `core_req` high: core wins.
  - Only `host_req` high: host wins.
  - Both high: the requester that is not `last_grant` wins (round-robin).
- Core win: one access in the same cycle. `core_gnt`=1, `mem_*` = core fields, `last_grant`←0, and the FSM stays in IDLE.
- Host win in IDLE (beat 0):
  - Outputs: `host_gnt`=1, `mem_*` address = `host_addr`.
  - Latch `base_addr`←`host_addr` and `burst_len`←`host_len`.
  - If `host_len`=0: assert `host_last` and stay in IDLE.
  - Otherwise: `beat_cnt`←1, go to BURST.
  - In both cases `last_grant`←1.
- BURST, each cycle:
  - `host_gnt`=1 and `core_gnt`=0.
  - Address = `base_addr + beat_cnt` mod 2^ADDR_W, so 31 wraps to 0.
  - `beat_cnt` increments each cycle.
  - When `beat_cnt == burst_len`: assert `host_last` and return to IDLE.
- A burst is never preempted. `host_req` is ignored during BURST.
- `mem_we` = granted requester's `we`. When nothing is granted: `mem_we`=0 and the address/data outputs = 0.
- Fairness:
  - After a burst, `last_grant`=1, so a waiting core wins the next contended cycle.
  - The core's worst-case wait is 2^LEN_W cycles.

## Timing
- Core access latency is 0 cycles when uncontended. Read data is valid combinationally in the grant cycle; writes commit at the next rising `clk`.
- A host burst of N = `host_len`+1 beats occupies exactly N consecutive cycles, with one beat per cycle and no bubbles.
- Reset, applied at any time including mid-burst:
  - Next state: `state`=IDLE, `beat_cnt`=0, `burst_len`=0, `base_addr`=0, `last_grant`=1.
  - While `rst` is high: `core_gnt`, `host_gnt`, `host_last` and `mem_we` are forced to 0, `core_stall` = `core_req`, and the address/data outputs are 0.
  - A burst interrupted by reset is abandoned; beats already written stay written.
- Simultaneous events:
  - A new `host_req` in the cycle `host_last` is asserted is not serviced until the next IDLE cycle.
  - A core request arriving in that same cycle wins the next IDLE cycle if `last_grant`=1.

## Test plan
- Reset, then core only, `core_we`=1, `core_addr`=3, `core_wdata`=0x5A -> `core_gnt`=1 in the same cycle, `mem_we`=1, `mem_write_addr`=3; a read of 3 on the next cycle returns 0x5A.
- After reset, `core_req` and `host_req` high together for two cycles with `host_len`=0 -> cycle 1: core granted; cycle 2: host granted with `host_last`=1.
- Host burst write, `host_addr`=30, `host_len`=3, data 0x11/0x22/0x33/0x44, with `core_req` held high throughout -> addresses 30, 31, 0, 1; `host_last` on the 4th beat; `core_stall`=1 for 4 cycles; core granted on the 5th cycle.
- Host burst read of 8 beats from 0 -> `host_rdata` follows memory contents at addresses 0..7 on consecutive `host_gnt` cycles; `mem_we`=0 throughout.
- `rst` pulsed on beat 2 of a 6-beat write burst -> no `mem_we` during the reset cycle; the next cycle is IDLE; a pending `core_req` is granted; the remaining beats are never written.
- Back-to-back single-beat host bursts with `core_req` held high -> grants strictly alternate core/host.
